// File: rtl/axi_llc_flush_walker.sv
// rtl/axi_llc_flush_walker.sv - tag-store flush walker with writeback forwarding

package axi_llc_pkg;
    typedef enum logic [1:0] {
        BIST   = 2'd0,
        FLUSH  = 2'd1,
        LOOKUP = 2'd2
    } llc_mode_e;
endpackage

module axi_llc_flush_walker #(
    parameter int unsigned SetAssociativity = 8,
    parameter int unsigned NumLines         = 256,
    parameter int unsigned TagLength        = 20,
    parameter int unsigned IndexLength      = $clog2(NumLines),
    parameter int unsigned WayIdxWidth      = (SetAssociativity > 1) ? $clog2(SetAssociativity) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_valid_i,
    output logic                         flush_ready_o,
    input  logic [SetAssociativity-1:0]  flush_ways_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [SetAssociativity-1:0]  flushed_o,
    input  logic [SetAssociativity-1:0]  flushed_clr_i,
    output logic                         store_req_valid_o,
    input  logic                         store_req_ready_i,
    output axi_llc_pkg::llc_mode_e       store_req_mode_o,
    output logic [SetAssociativity-1:0]  store_req_indicator_o,
    output logic [IndexLength-1:0]       store_req_index_o,
    input  logic                         store_res_valid_i,
    output logic                         store_res_ready_o,
    input  logic                         store_res_evict_i,
    input  logic [TagLength-1:0]         store_res_evict_tag_i,
    output logic                         wb_valid_o,
    input  logic                         wb_ready_i,
    output logic [WayIdxWidth-1:0]       wb_way_o,
    output logic [IndexLength-1:0]       wb_index_o,
    output logic [TagLength-1:0]         wb_tag_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RESP = 3'd2,
        WB   = 3'd3,
        DONE = 3'd4
    } state_e;

    localparam logic [IndexLength-1:0] LastIndex = IndexLength'(NumLines - 1);

    state_e                        state_q, state_d;
    logic [SetAssociativity-1:0]   mask_q, mask_d;
    logic [SetAssociativity-1:0]   way_q, way_d;
    logic [IndexLength-1:0]        index_q, index_d;
    logic [TagLength-1:0]          tag_q, tag_d;
    logic [SetAssociativity-1:0]   flushed_q;
    logic [SetAssociativity-1:0]   flushed_set;
    logic [SetAssociativity-1:0]   mask_left;
    logic                          advance;

    logic                          flush_ready_q;
    logic                          busy_q;
    logic                          done_q;
    logic                          req_valid_q;
    logic                          res_ready_q;
    logic                          wb_valid_q;
    logic [WayIdxWidth-1:0]        wb_way_q;

    // One-hot of the lowest set bit; empty input gives empty output.
    function automatic logic [SetAssociativity-1:0] lowest_way(input logic [SetAssociativity-1:0] m);
        logic [SetAssociativity-1:0] r;
        logic                        found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < int'(SetAssociativity); i++) begin
            if (m[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Binary encoding of a one-hot way vector.
    function automatic logic [WayIdxWidth-1:0] way_bin(input logic [SetAssociativity-1:0] w);
        logic [WayIdxWidth-1:0] r;
        r = '0;
        for (int i = 0; i < int'(SetAssociativity); i++) begin
            if (w[i]) begin
                r = WayIdxWidth'(i);
            end
        end
        return r;
    endfunction

    // Next-state logic: walk indices of the current way, then move to the next selected way.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        way_d       = way_q;
        index_d     = index_q;
        tag_d       = tag_q;
        flushed_set = '0;
        advance     = 1'b0;
        mask_left   = mask_q & ~way_q;

        unique case (state_q)
            IDLE: begin
                if (flush_valid_i) begin
                    if (|flush_ways_i) begin
                        mask_d  = flush_ways_i;
                        way_d   = lowest_way(flush_ways_i);
                        index_d = '0;
                        state_d = REQ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            REQ: begin
                if (store_req_ready_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (store_res_valid_i) begin
                    if (store_res_evict_i) begin
                        tag_d   = store_res_evict_tag_i;
                        state_d = WB;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            WB: begin
                if (wb_ready_i) begin
                    advance = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            if (index_q != LastIndex) begin
                index_d = index_q + IndexLength'(1);
                state_d = REQ;
            end else begin
                flushed_set = way_q;
                mask_d      = mask_left;
                if (mask_left == '0) begin
                    state_d = DONE;
                end else begin
                    way_d   = lowest_way(mask_left);
                    index_d = '0;
                    state_d = REQ;
                end
            end
        end
    end

    // State, walk registers and registered handshake/status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            mask_q        <= '0;
            way_q         <= '0;
            index_q       <= '0;
            tag_q         <= '0;
            flushed_q     <= '0;
            flush_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            req_valid_q   <= 1'b0;
            res_ready_q   <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_way_q      <= '0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            way_q         <= way_d;
            index_q       <= index_d;
            tag_q         <= tag_d;
            flushed_q     <= (flushed_q & ~flushed_clr_i) | flushed_set;
            flush_ready_q <= (state_d == IDLE);
            busy_q        <= (state_d != IDLE);
            done_q        <= (state_d == DONE);
            req_valid_q   <= (state_d == REQ);
            res_ready_q   <= (state_d == RESP);
            wb_valid_q    <= (state_d == WB);
            wb_way_q      <= way_bin(way_d);
        end
    end

    assign flush_ready_o         = flush_ready_q;
    assign busy_o                = busy_q;
    assign done_o                = done_q;
    assign flushed_o             = flushed_q;
    assign store_req_valid_o     = req_valid_q;
    assign store_req_mode_o      = axi_llc_pkg::FLUSH;
    assign store_req_indicator_o = way_q;
    assign store_req_index_o     = index_q;
    assign store_res_ready_o     = res_ready_q;
    assign wb_valid_o            = wb_valid_q;
    assign wb_way_o              = wb_way_q;
    assign wb_index_o            = index_q;
    assign wb_tag_o              = tag_q;

    // The tag store only answers requests, so a response outside RESP is a protocol error.
    a_no_stray_response: assert property (@(posedge clk_i) disable iff (rst_i)
        store_res_valid_i |-> (state_q == RESP));

endmodule

// File: tb/tb_axi_llc_flush_walker.sv
// tb/tb_axi_llc_flush_walker.sv - self-checking bench for axi_llc_flush_walker

module tb_axi_llc_flush_walker;

    localparam int SA = 8;
    localparam int NL = 4;
    localparam int TL = 20;
    localparam int IL = 2;
    localparam int WW = 3;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                   rst_i = 1'b1;
    logic                   flush_valid_i = 1'b0;
    logic                   flush_ready_o;
    logic [SA-1:0]          flush_ways_i = '0;
    logic                   busy_o;
    logic                   done_o;
    logic [SA-1:0]          flushed_o;
    logic [SA-1:0]          flushed_clr_i = '0;
    logic                   store_req_valid_o;
    logic                   store_req_ready_i = 1'b0;
    axi_llc_pkg::llc_mode_e store_req_mode_o;
    logic [SA-1:0]          store_req_indicator_o;
    logic [IL-1:0]          store_req_index_o;
    logic                   store_res_valid_i = 1'b0;
    logic                   store_res_ready_o;
    logic                   store_res_evict_i = 1'b0;
    logic [TL-1:0]          store_res_evict_tag_i = '0;
    logic                   wb_valid_o;
    logic                   wb_ready_i = 1'b0;
    logic [WW-1:0]          wb_way_o;
    logic [IL-1:0]          wb_index_o;
    logic [TL-1:0]          wb_tag_o;

    axi_llc_flush_walker #(
        .SetAssociativity (SA),
        .NumLines         (NL),
        .TagLength        (TL)
    ) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .flush_valid_i         (flush_valid_i),
        .flush_ready_o         (flush_ready_o),
        .flush_ways_i          (flush_ways_i),
        .busy_o                (busy_o),
        .done_o                (done_o),
        .flushed_o             (flushed_o),
        .flushed_clr_i         (flushed_clr_i),
        .store_req_valid_o     (store_req_valid_o),
        .store_req_ready_i     (store_req_ready_i),
        .store_req_mode_o      (store_req_mode_o),
        .store_req_indicator_o (store_req_indicator_o),
        .store_req_index_o     (store_req_index_o),
        .store_res_valid_i     (store_res_valid_i),
        .store_res_ready_o     (store_res_ready_o),
        .store_res_evict_i     (store_res_evict_i),
        .store_res_evict_tag_i (store_res_evict_tag_i),
        .wb_valid_o            (wb_valid_o),
        .wb_ready_i            (wb_ready_i),
        .wb_way_o              (wb_way_o),
        .wb_index_o            (wb_index_o),
        .wb_tag_o              (wb_tag_o)
    );

    typedef struct {
        logic [SA-1:0] ind;
        logic [IL-1:0] idx;
    } req_t;

    typedef struct {
        logic [WW-1:0] way;
        logic [IL-1:0] idx;
        logic [TL-1:0] tag;
    } wb_t;

    req_t exp_req_q[$];
    wb_t  exp_wb_q[$];

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    int            req_stall_cfg = 0;
    int            wb_stall_cfg  = 0;
    int            evict_idx     = -1;
    logic [TL-1:0] evict_tag     = '0;
    bit            res_hold      = 1'b0;
    bit            clr_on_last   = 1'b0;
    logic [SA-1:0] clr_manual    = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_way(input int way);
        req_t r;
        for (int i = 0; i < NL; i++) begin
            r.ind = SA'(1) << way;
            r.idx = IL'(i);
            exp_req_q.push_back(r);
        end
    endtask

    // Tag-store and eviction-path model; all handshakes decided at the falling edge.
    always @(negedge clk_i) begin : responder
        static bit            req_hs = 0, res_hs = 0, wb_hs = 0;
        static bit            pending = 0, seen = 0, wb_seen = 0, done_prev = 0;
        static int            stall_left = 0, wb_left = 0;
        static logic [SA-1:0] cap_ind = '0;
        static logic [IL-1:0] cap_idx = '0, last_idx = '0;
        static wb_t           cap_wb;
        logic [SA-1:0]        clr_v;
        req_t                 er;
        if (rst_i) begin
            req_hs = 0; res_hs = 0; wb_hs = 0; pending = 0; seen = 0; wb_seen = 0; done_prev = 0;
            store_req_ready_i = 1'b0;
            store_res_valid_i = 1'b0;
            store_res_evict_i = 1'b0;
            wb_ready_i        = 1'b0;
            flushed_clr_i     = '0;
        end else begin
            clr_v = clr_manual;
            if (req_hs) begin store_req_ready_i = 1'b0; req_hs = 0; pending = 1; end
            if (res_hs) begin store_res_valid_i = 1'b0; store_res_evict_i = 1'b0; res_hs = 0; end
            if (wb_hs)  begin wb_ready_i = 1'b0; wb_hs = 0; end

            if (done_o) begin
                done_cnt++;
                chk("done_single_cycle", 32'(done_prev), 32'd0);
            end
            done_prev = done_o;

            if (store_req_valid_o && !store_req_ready_i) begin
                if (!seen) begin
                    seen       = 1;
                    stall_left = req_stall_cfg;
                    cap_ind    = store_req_indicator_o;
                    cap_idx    = store_req_index_o;
                end else begin
                    chk("req_ind_stable", 32'(store_req_indicator_o), 32'(cap_ind));
                    chk("req_idx_stable", 32'(store_req_index_o), 32'(cap_idx));
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    store_req_ready_i = 1'b1;
                    req_hs   = 1;
                    seen     = 0;
                    last_idx = store_req_index_o;
                    chk("req_mode", 32'(store_req_mode_o), 32'(axi_llc_pkg::FLUSH));
                    if (exp_req_q.size() == 0) begin
                        chk("req_unexpected", 32'(store_req_index_o), 32'hFFFF_FFFF);
                    end else begin
                        er = exp_req_q.pop_front();
                        chk("req_indicator", 32'(store_req_indicator_o), 32'(er.ind));
                        chk("req_index", 32'(store_req_index_o), 32'(er.idx));
                    end
                end
            end

            if (pending && !res_hold && store_res_ready_o && !store_res_valid_i) begin
                store_res_valid_i     = 1'b1;
                store_res_evict_i     = (int'(last_idx) == evict_idx);
                store_res_evict_tag_i = evict_tag;
                pending = 0;
                res_hs  = 1;
                if (clr_on_last && last_idx == IL'(NL - 1)) clr_v = clr_v | 8'h04;
            end
            flushed_clr_i = clr_v;

            if (wb_valid_o && !wb_ready_i) begin
                chk("no_req_during_wb", 32'(store_req_valid_o), 32'd0);
                if (!wb_seen) begin
                    wb_seen    = 1;
                    wb_left    = wb_stall_cfg;
                    cap_wb.way = wb_way_o;
                    cap_wb.idx = wb_index_o;
                    cap_wb.tag = wb_tag_o;
                    if (exp_wb_q.size() == 0) begin
                        chk("wb_unexpected", 32'(wb_index_o), 32'hFFFF_FFFF);
                    end else begin
                        wb_t ew;
                        ew = exp_wb_q.pop_front();
                        chk("wb_way", 32'(wb_way_o), 32'(ew.way));
                        chk("wb_index", 32'(wb_index_o), 32'(ew.idx));
                        chk("wb_tag", 32'(wb_tag_o), 32'(ew.tag));
                    end
                end else begin
                    chk("wb_way_stable", 32'(wb_way_o), 32'(cap_wb.way));
                    chk("wb_tag_stable", 32'(wb_tag_o), 32'(cap_wb.tag));
                end
                if (wb_left > 0) begin
                    wb_left--;
                end else begin
                    wb_ready_i = 1'b1;
                    wb_hs      = 1;
                    wb_seen    = 0;
                end
            end
        end
    end

    task automatic run_cmd(input logic [SA-1:0] ways, input string tag);
        int start;
        start = done_cnt;
        flush_ways_i  = ways;
        flush_valid_i = 1'b1;
        chk({tag, "_flush_ready"}, 32'(flush_ready_o), 32'd1);
        @(negedge clk_i);
        flush_valid_i = 1'b0;
        chk({tag, "_busy"}, 32'(busy_o), 32'd1);
        chk({tag, "_ready_low"}, 32'(flush_ready_o), 32'd0);
        for (int c = 0; c < 400 && done_cnt == start; c++) @(negedge clk_i);
        repeat (3) @(negedge clk_i);
        chk({tag, "_done_pulses"}, 32'(done_cnt - start), 32'd1);
        chk({tag, "_req_left"}, 32'(exp_req_q.size()), 32'd0);
        chk({tag, "_wb_left"}, 32'(exp_wb_q.size()), 32'd0);
        chk({tag, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int   start;
        wb_t  w;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        chk("rst_flush_ready", 32'(flush_ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_flushed", 32'(flushed_o), 32'd0);
        chk("rst_req_valid", 32'(store_req_valid_o), 32'd0);
        chk("rst_res_ready", 32'(store_res_ready_o), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);

        push_way(2);
        run_cmd(8'h04, "way2_clean");
        chk("way2_clean_flushed", 32'(flushed_o), 32'h04);

        evict_idx    = 2;
        evict_tag    = 20'h12345;
        wb_stall_cfg = 5;
        push_way(2);
        w.way = 3'd2; w.idx = 2'd2; w.tag = 20'h12345;
        exp_wb_q.push_back(w);
        run_cmd(8'h04, "way2_evict");
        evict_idx    = -1;
        wb_stall_cfg = 0;

        clr_manual = 8'hFF;
        repeat (2) @(negedge clk_i);
        chk("clr_all_flushed", 32'(flushed_o), 32'd0);
        clr_manual = 8'h00;
        repeat (2) @(negedge clk_i);

        push_way(0);
        push_way(7);
        run_cmd(8'h81, "ways_0_7");
        chk("ways_0_7_flushed", 32'(flushed_o), 32'h81);

        start = done_cnt;
        flush_ways_i  = 8'h00;
        flush_valid_i = 1'b1;
        chk("zero_flush_ready", 32'(flush_ready_o), 32'd1);
        @(negedge clk_i);
        flush_valid_i = 1'b0;
        chk("zero_done_high", 32'(done_o), 32'd1);
        @(negedge clk_i);
        chk("zero_done_low", 32'(done_o), 32'd0);
        chk("zero_idle", 32'(busy_o), 32'd0);
        repeat (2) @(negedge clk_i);
        chk("zero_done_pulses", 32'(done_cnt - start), 32'd1);
        chk("zero_flushed_kept", 32'(flushed_o), 32'h81);

        req_stall_cfg = 3;
        clr_on_last   = 1'b1;
        push_way(2);
        run_cmd(8'h04, "stall_setwins");
        chk("stall_setwins_flushed", 32'(flushed_o), 32'h85);
        req_stall_cfg = 0;
        clr_on_last   = 1'b0;

        res_hold = 1'b1;
        begin
            req_t r;
            r.ind = 8'h04; r.idx = 2'd0;
            exp_req_q.push_back(r);
        end
        start = done_cnt;
        flush_ways_i  = 8'h04;
        flush_valid_i = 1'b1;
        @(negedge clk_i);
        flush_valid_i = 1'b0;
        for (int c = 0; c < 50 && !store_res_ready_o; c++) @(negedge clk_i);
        chk("midrst_in_resp", 32'(store_res_ready_o), 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("midrst_flush_ready", 32'(flush_ready_o), 32'd1);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_req_valid", 32'(store_req_valid_o), 32'd0);
        chk("midrst_res_ready", 32'(store_res_ready_o), 32'd0);
        chk("midrst_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("midrst_flushed", 32'(flushed_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);
        rst_i    = 1'b0;
        res_hold = 1'b0;
        repeat (5) @(negedge clk_i);
        chk("midrst_no_done", 32'(done_cnt - start), 32'd0);
        chk("midrst_req_left", 32'(exp_req_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
